knn_result_reader: RTL
======================

# knn_result_reader

- Drains the K nearest-neighbour results from the KNN sorter once a classification pass has finished.
- Steps the sorter's `SEL` readout port from 0 to HW_K-1 and captures each `DATA_OUT` word.
- Emits each captured word, in order, on a valid/ready stream toward the CPU-side FIFO/register bank.
- Sits downstream of the sorter's readout port, replacing software polling of `SEL`.

## Interface
Parameters:
- `W`, 32: datapath width; readout words and `SEL` are W/2 bits.
- `HW_K`, 10: number of sorter entries to read; legal range 1..2^(W/2)-1.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset, synchronous, active-low (asserted when 0).
- `start`  in  1  one-cycle pulse; sorter results are stable and ready to read.
- `DATA_IN`  in  W/2  sorter `DATA_OUT` for the current `SEL`; valid one clock after `SEL` changes.
- `SEL`  out  W/2  entry index driven to the sorter.
- `m_valid`  out  1  output word valid.
- `m_ready`  in  1  downstream accepts the word.
- `m_data`  out  W/2  captured entry.
- `m_idx`  out  W/2  index of `m_data` (0 = nearest neighbour).
- `busy`  out  1  a readout pass is in progress.
- `done`  out  1  one-cycle pulse after the last word is accepted.

## Operation
- FSM states: IDLE, ADDR, CAPT, SEND, FIN.
- IDLE: `busy`=0. On `start`=1: `SEL`←0, index←0, `busy`←1, go to ADDR.
- ADDR: waits one cycle for the sorter readout latency, then goes to CAPT.
- CAPT: `m_data`←`DATA_IN`, `m_idx`←index, `m_valid`←1, go to SEND.
- SEND: holds `m_valid`, `m_data` and `m_idx` stable until `m_valid`&`m_ready`. On that handshake edge:
  - `m_valid`←0.
  - If index==HW_K-1: go to FIN.
  - Otherwise: index←index+1, `SEL`←index+1, go to ADDR.
- FIN: `done`=1 for exactly this cycle, `busy`=0, then return to IDLE.
- `start` is ignored in every state except IDLE, including FIN.
- `SEL` holds its last value while IDLE; it changes only on `start` or on a handshake.
- Index compare uses the full W/2 bits; HW_K=1 goes straight from the first handshake to FIN.
- Reset (rst=0 at a clock edge) is honoured in any state, including mid-pass with `m_valid`=1.
  - All outputs are 0 on the following cycle: `SEL`, `m_valid`, `m_data`, `m_idx`, `busy`, `done`; FSM in IDLE.
  - The word that was pending is dropped.

## Timing
- Start edge E0 (`start`=1 sampled): after E0, `busy`=1 and `SEL`=0.
- First word: `DATA_IN` is sampled at E2; `m_valid`=1 after E2.
- Each entry costs 3 cycles with `m_ready` tied high: handshake, ADDR, CAPT.
- Handshakes fall at E3, E6, …, E(3·HW_K).
- `done`=1 in the cycle after E(3·HW_K); `busy` drops to 0 at the same point.
- Each cycle of `m_ready`=0 in SEND adds exactly one cycle.
- `m_ready` is never sampled outside SEND.
- Outputs are registered; there are no combinational paths from `m_ready` or `DATA_IN` to any output.

## Configuration
- `KNN_READER_LAST_EN` defined:
  - Adds output port `m_last` (1 bit), high together with `m_valid` for the index HW_K-1 word, 0 otherwise; reset value 0.
  - Lets the CPU DMA close a burst without counting words.
- Undefined: the port does not exist and behaviour is otherwise identical.

## Test plan
- Reset: hold rst=0 for 3 cycles with `start`=1 -> all outputs 0, `busy` never asserts.
- Full drain: sorter model returns 100+SEL with a 1-cycle latency, HW_K=10, `m_ready`=1, `start` at E0 -> words 100..109 with `m_idx` 0..9, handshakes at E3..E30 (3-cycle stride), `done` pulse right after E30.
- Backpressure: `m_ready` low for 5 cycles on index 4 -> `m_data`=104 held stable, no `SEL` change during the stall, `done` 5 cycles later than in the full-drain test.
- Mid-pass reset: rst=0 while SEND at index 6 -> next cycle all outputs 0; a new `start` restarts at index 0.
- Ignored start: pulse `start` at index 3 and again in the FIN cycle -> sequence unchanged, exactly one `done`, returns to IDLE.
- Macro: with `KNN_READER_LAST_EN` and HW_K=1 -> a single word where `m_last`=1 and `m_valid`=1 in the same cycles, `done` right after the handshake.

Source files
------------

// File: rtl/knn_result_reader.sv
// Drains HW_K nearest-neighbour entries from the sorter readout port onto a valid/ready stream.
// Optional `KNN_READER_LAST_EN adds an m_last flag on the final word.
module knn_result_reader #(
    parameter int W    = 32,
    parameter int HW_K = 10
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [W/2-1:0] DATA_IN,
    output logic [W/2-1:0] SEL,
    output logic           m_valid,
    input  logic           m_ready,
    output logic [W/2-1:0] m_data,
    output logic [W/2-1:0] m_idx,
`ifdef KNN_READER_LAST_EN
    output logic           m_last,
`endif
    output logic           busy,
    output logic           done
);

    localparam int HW = W / 2;
    localparam logic [HW-1:0] LAST_IDX = HW'(HW_K - 1);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] ADDR = 3'd1;
    localparam logic [2:0] CAPT = 3'd2;
    localparam logic [2:0] SEND = 3'd3;
    localparam logic [2:0] FIN  = 3'd4;

    logic [2:0]    state;
    logic [HW-1:0] index;
    logic          last_entry;
    logic [HW-1:0] next_index;

    assign last_entry = (index == LAST_IDX);
    assign next_index = index + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            index   <= '0;
            SEL     <= '0;
            m_valid <= 1'b0;
            m_data  <= '0;
            m_idx   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
`ifdef KNN_READER_LAST_EN
            m_last  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        SEL   <= '0;
                        index <= '0;
                        busy  <= 1'b1;
                        state <= ADDR;
                    end
                end
                // one idle cycle covers the sorter's registered readout after SEL moves
                ADDR: begin
                    state <= CAPT;
                end
                CAPT: begin
                    m_data  <= DATA_IN;
                    m_idx   <= index;
                    m_valid <= 1'b1;
`ifdef KNN_READER_LAST_EN
                    m_last  <= last_entry;
`endif
                    state   <= SEND;
                end
                SEND: begin
                    if (m_ready) begin
                        m_valid <= 1'b0;
`ifdef KNN_READER_LAST_EN
                        m_last  <= 1'b0;
`endif
                        if (last_entry) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= FIN;
                        end else begin
                            index <= next_index;
                            SEL   <= next_index;
                            state <= ADDR;
                        end
                    end
                end
                FIN: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    m_valid <= 1'b0;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule
